dec_sel_scanner: RTL and testbench

Upstream select generator for the 3-to-8 decoder stage. On a start request it steps a 3-bit select code (sel_a = MSB, sel_c = LSB) through 0..7, holding each code for a programmable dwell. Each select line drives the matching decoder input directly. It supports single-pass and continuous (looping) scans with abort, and reports completion through a one-cycle done pulse.

---
 rtl/dec_sel_scanner.sv | 132 +++++++++++++
 tb/tb_dec_sel_scanner.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dec_sel_scanner.sv
// Select-code generator for the 3-to-8 decoder stage: steps {sel_a,sel_b,sel_c}
// through 0..7 with a programmable dwell per code, in single-pass or looping mode.
module dec_sel_scanner #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    output logic               sel_a,
    output logic               sel_b,
    output logic               sel_c,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DWELL_W-1:0] CNT_ZERO = '0;
    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] reload_q, reload_d;
    logic               loop_q, loop_d;
    logic               sel_valid_q, sel_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] dwell_m1;

    // A dwell of 0 behaves as 1, so the reload value saturates at zero.
    assign dwell_m1 = (dwell == CNT_ZERO) ? CNT_ZERO : (dwell - CNT_ONE);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        reload_d    = reload_q;
        loop_d      = loop_q;
        sel_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wrap_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d     = ST_RUN;
                    sel_d       = 3'd0;
                    cnt_d       = dwell_m1;
                    reload_d    = dwell_m1;
                    loop_d      = loop;
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    sel_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    if (cnt_q != CNT_ZERO) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (sel_q != 3'd7) begin
                        sel_d = sel_q + 3'd1;
                        cnt_d = reload_q;
                    end else if (loop_q) begin
                        sel_d  = 3'd0;
                        cnt_d  = reload_q;
                        wrap_d = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        sel_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= 3'd0;
            cnt_q       <= CNT_ZERO;
            reload_q    <= CNT_ZERO;
            loop_q      <= 1'b0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            reload_q    <= reload_d;
            loop_q      <= loop_d;
            sel_valid_q <= sel_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wrap_q      <= wrap_d;
        end
    end

    assign sel_a     = sel_q[2];
    assign sel_b     = sel_q[1];
    assign sel_c     = sel_q[0];
    assign sel_valid = sel_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_dec_sel_scanner.sv
// Scoreboard bench for dec_sel_scanner: each scan pushes its expected
// per-cycle output stream; a negedge monitor pops and compares.
module tb_dec_sel_scanner;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          loop;
    logic [DW-1:0] dwell;
    logic          sel_a, sel_b, sel_c;
    logic          sel_valid, busy, done, wrap;

    int checks = 0;
    int errors = 0;
    int lastSel = 0;

    // Entry layout: {sel[2:0], sel_valid, busy, done, wrap}
    logic [6:0] expQ[$];

    dec_sel_scanner #(.DWELL_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .loop     (loop),
        .dwell    (dwell),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .sel_c    (sel_c),
        .sel_valid(sel_valid),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Monitor: any active output cycle must match the next expected entry.
    initial begin
        logic [6:0] obs;
        logic [6:0] exp;
        forever begin
            @(negedge clk);
            obs = {sel_a, sel_b, sel_c, sel_valid, busy, done, wrap};
            if (sel_valid === 1'b1 || busy === 1'b1 || done === 1'b1 || wrap === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", {25'd0, obs}, 32'd0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("stream", {25'd0, obs}, {25'd0, exp});
                end
            end
        end
    end

    // One scan. stopEdge>0 ends it at that edge (abort, or reset when useRst).
    task automatic applyStimulus(input int dv, input bit lp, input int stopEdge,
                                 input bit useRst, input bit disturb);
        int d;
        int pass;
        int nEntries;
        int endEdge;
        logic [2:0] s;
        logic w;
        d        = (dv == 0) ? 1 : dv;
        pass     = 8 * d;
        nEntries = (stopEdge > 0) ? stopEdge : pass;
        for (int t = 0; t < nEntries; t++) begin
            s = 3'((t / d) % 8);
            w = lp && (t > 0) && (t % pass == 0);
            expQ.push_back({s, 1'b1, 1'b1, 1'b0, w});
        end
        if (stopEdge == 0) begin
            expQ.push_back({3'd7, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        if (useRst) lastSel = 0;
        else if (stopEdge == 0) lastSel = 7;
        else lastSel = ((stopEdge - 1) / d) % 8;
        endEdge = (stopEdge > 0) ? stopEdge : pass + 1;

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; dwell = DW'(dv); loop = lp;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) begin
            dwell = DW'($urandom);
            loop  = ~lp;
        end
        for (int j = 1; j <= endEdge; j++) begin
            abort = (j == stopEdge && !useRst) ||
                    (disturb && stopEdge == 0 && j == pass + 1);
            rst_n = !(j == stopEdge && useRst);
            start = disturb && (j <= pass) && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drain", expQ.size(), 0);
        expQ.delete();
        checkOutput("idle_busy", {31'd0, busy}, 0);
        checkOutput("idle_valid", {31'd0, sel_valid}, 0);
        checkOutput("idle_sel", {29'd0, sel_a, sel_b, sel_c}, lastSel);
    endtask

    initial begin
        int dv;
        int d;
        bit lp;
        int ab;
        bit ur;
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; loop = 1'b0; dwell = DW'(4);
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("reset_flags", {28'd0, sel_valid, busy, done, wrap}, 0);
        checkOutput("reset_sel", {29'd0, sel_a, sel_b, sel_c}, 0);
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_idle", {31'd0, busy}, 0);

        applyStimulus(4, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 21, 1'b0, 1'b0);

        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        checkOutput("start_abort_idle", {30'd0, sel_valid, busy}, 0);

        applyStimulus(4, 1'b0, 0, 1'b0, 1'b1);
        applyStimulus(4, 1'b0, 10, 1'b1, 1'b0);
        applyStimulus(255, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 50, 1'b0, 1'b1);

        repeat (24) begin
            dv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
            d  = (dv == 0) ? 1 : dv;
            lp = 1'($urandom_range(0, 1));
            if (lp) ab = $urandom_range(1, 16 * d + 3);
            else ab = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8 * d));
            ur = (ab > 0) && ($urandom_range(0, 3) == 0);
            applyStimulus(dv, lp, ab, ur, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
